// File: rtl/bip_pkg.sv
// Shared constants for the BIP data-memory slice: bus widths, sequencer state
// encoding and the access-counter saturation helper.
package bip_pkg;

  localparam int BIP_DATA_WIDTH = 16;
  localparam int BIP_ADDR_WIDTH = 11;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + 16'd1;
  endfunction

endpackage

// File: rtl/bip_ram_core.sv
// Single-port synchronous RAM: one write port and a registered read port,
// written in the plain form block-RAM inference expects.
module bip_ram_core #(
  parameter int DW    = 16,
  parameter int DEPTH = 2048,
  parameter int IW    = 11
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [IW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bip_data_memory.sv
// Clocked BIP data memory: power-up clear sequencer, range checking,
// write-first read mux and saturating access counters around bip_ram_core.
module bip_data_memory
  import bip_pkg::*;
#(
  parameter int DATA_WIDTH     = BIP_DATA_WIDTH,
  parameter int ADDR_WIDTH     = BIP_ADDR_WIDTH,
  parameter int DEPTH          = 2048,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Rd,
  input  logic                  Wr,
  input  logic [ADDR_WIDTH-1:0] DataAddr,
  input  logic [DATA_WIDTH-1:0] In_Data,
  output logic [DATA_WIDTH-1:0] Out_Data,
  output logic                  Ready,
  output logic                  AddrError,
  output logic [15:0]           RdCount,
  output logic [15:0]           WrCount
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [0:0]            state_q, state_d;
  logic [IW-1:0]         clr_ptr_q, clr_ptr_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic [15:0]           rd_cnt_q, rd_cnt_d;
  logic [15:0]           wr_cnt_q, wr_cnt_d;

  logic                  in_range, clearing;
  logic                  acc_rd, acc_wr;
  logic                  ram_we, ram_re;
  logic [IW-1:0]         ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

  assign in_range = (32'(DataAddr) < 32'(DEPTH));
  assign clearing = (state_q == ST_CLEAR);
  assign acc_rd   = ready_q & Rd & ~Reset;
  assign acc_wr   = ready_q & Wr & ~Reset;

  assign ram_we    = ~Reset & (clearing | (acc_wr & in_range));
  assign ram_re    = acc_rd & ~Wr & in_range;
  assign ram_addr  = clearing ? clr_ptr_q : DataAddr[IW-1:0];
  assign ram_wdata = clearing ? '0 : In_Data;

  bip_ram_core #(
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_ram (
    .clk_i   (Clock),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // A pure read returns the RAM's registered word for one cycle; afterwards
  // out_q captures it so Out_Data keeps holding that value.
  assign Out_Data  = rd_pend_q ? ram_rdata : out_q;
  assign Ready     = ready_q;
  assign AddrError = err_q;
  assign RdCount   = rd_cnt_q;
  assign WrCount   = wr_cnt_q;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    out_d     = Out_Data;
    rd_pend_d = 1'b0;
    ready_d   = ready_q;
    err_d     = err_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    if (Reset) begin
      state_d   = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_ptr_d = '0;
      out_d     = '0;
      ready_d   = 1'b0;
      err_d     = 1'b0;
      rd_cnt_d  = '0;
      wr_cnt_d  = '0;
    end else begin
      if (clearing) begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == IW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end else begin
        ready_d = 1'b1;
      end
      if (acc_rd) rd_cnt_d = sat_inc(rd_cnt_q);
      if (acc_wr) wr_cnt_d = sat_inc(wr_cnt_q);
      if ((acc_rd | acc_wr) & ~in_range) err_d = 1'b1;
      if (acc_rd) begin
        if (!in_range)  out_d = '0;
        else if (acc_wr) out_d = In_Data;
        else            rd_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    state_q   <= state_d;
    clr_ptr_q <= clr_ptr_d;
    out_q     <= out_d;
    rd_pend_q <= rd_pend_d;
    ready_q   <= ready_d;
    err_q     <= err_d;
    rd_cnt_q  <= rd_cnt_d;
    wr_cnt_q  <= wr_cnt_d;
  end

endmodule

// File: doc/bip_data_memory.md
Name: bip_data_memory

Overview:
Synchronous data-memory responder for the BIP CPU data bus; it services the CPU's Rd/Wr/DataAddr/In_Data requests and returns read data on Out_Data.
- Replaces the combinational behavioural memory used in CPU-level benches with a synthesizable, clocked block.
- Adds a power-up clear sequencer, out-of-range detection and access counters for software-level verification (e.g. confirming A returns to 0 after the LDi/ADDi/SUBi/STO sequence).

Parameters:
DATA_WIDTH, 16, data word width (matches CPU accumulator)
ADDR_WIDTH, 11, data address width (matches CPU operand field)
DEPTH, 2048, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH
CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents untouched by reset

Ports:
Clock  in  1  system clock, all state updates on rising edge
Reset  in  1  reset, synchronous, active-high
Rd  in  1  CPU read strobe
Wr  in  1  CPU write strobe
DataAddr  in  ADDR_WIDTH  word address
In_Data  in  DATA_WIDTH  write data from CPU (CPU's output bus)
Out_Data  out  DATA_WIDTH  read data to CPU (CPU's input bus)
Ready  out  1  memory accepting accesses
AddrError  out  1  sticky: access with DataAddr >= DEPTH seen
RdCount  out  16  saturating count of accepted reads
WrCount  out  16  saturating count of accepted writes

Behaviour:
- Reset (sampled high at edge): state<=CLEAR if CLEAR_ON_RESET else IDLE; clr_ptr<=0; Out_Data<=0; Ready<=0; AddrError<=0; RdCount<=0; WrCount<=0. Reset dominates all other inputs.
- CLEAR: each cycle mem[clr_ptr]<=0, clr_ptr++. When clr_ptr==DEPTH-1, write last word, go IDLE. Exactly DEPTH clear cycles after Reset deasserts; Ready rises the edge the final word is written.
- CLEAR_ON_RESET=0: Ready=1 on first edge after Reset low; memory contents preserved.
- While Ready=0, Rd/Wr are ignored: no memory change, no counter change, Out_Data holds 0, AddrError unaffected.
- IDLE, in-range address (DataAddr < DEPTH):
  - Rd=1, Wr=0: Out_Data<=mem[DataAddr] at the edge. 1-cycle latency: valid after the edge where Rd was sampled. RdCount++.
  - Wr=1, Rd=0: mem[DataAddr]<=In_Data at the edge. Out_Data holds. WrCount++.
  - Rd=1, Wr=1: write performed; Out_Data<=In_Data (write-first). Both counters increment.
  - Rd=0, Wr=0: Out_Data holds last value.
- Read of an address written on the previous edge returns the new data. No stale-read hazard.
- Out of range (DataAddr >= DEPTH) with Rd or Wr: write dropped, Out_Data<=0 if Rd, AddrError<=1 (sticky until Reset). Counters still increment for the accepted strobes.
- Counters saturate at 16'hFFFF; no wrap.
- Reset asserted mid-CLEAR restarts the clear from address 0.
- Reset asserted during an access aborts it: no write occurs on that edge.
- Addresses are unsigned. No byte enables. Full-word accesses only.

Decomposition:
- Shared package bip_pkg holds:
  - BIP_DATA_WIDTH=16, BIP_ADDR_WIDTH=11
  - state encoding {CLEAR, IDLE}
  - CNT_MAX=16'hFFFF
- Sub-module bip_ram_core: single-port synchronous RAM, one write port and registered read; inferable as block RAM.
- bip_data_memory owns the FSM, clear pointer, range check, write-first mux, counters and status.

Test Plan:
1. Reset high 2 cycles then low, DEPTH=8, CLEAR_ON_RESET=1 -> Ready=0 for 8 cycles, then 1; reading addresses 0..7 all return 16'h0000.
2. Wr addr 0 data 16'h0001, next cycle Rd addr 0 -> Out_Data=16'h0001 one edge after the Rd; WrCount=1, RdCount=1.
3. Replay the STO sequence to addr 0 (0,1,3,6,3,1,0) then Rd addr 0 -> Out_Data=16'h0000; WrCount=7.
4. Rd=1,Wr=1, addr 5, In_Data=16'hBEEF -> Out_Data=16'hBEEF same edge; a later Rd addr 5 returns 16'hBEEF.
5. DEPTH=8, Wr addr 9 data 16'h1234, then Rd addr 9 -> AddrError=1 and stays 1; Out_Data=0; memory words 0..7 unchanged (addr 1 unaliased).
6. Rd held for 65540 cycles -> RdCount stops at 16'hFFFF. Reset asserted mid-CLEAR at clr_ptr=4 -> clear restarts at 0 and takes a full DEPTH cycles.
